// File: rtl/linebuf_fill_sched_if.sv
// rtl/linebuf_fill_sched_if.sv - layer requester handshake and line RAM write port bundle
interface linebuf_fill_sched_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic [2:0]      lyr_start;
    logic [2:0]      lyr_gnt;
    logic [2:0]      lyr_vld;
    logic [2:0]      lyr_last;
    logic [3*AW-1:0] lyr_adr;
    logic [3*DW-1:0] lyr_dat;
    logic [9:0]      lyr_line;
    logic            wr_en;
    logic            wr_bank;
    logic [AW-1:0]   wr_adr;
    logic [DW-1:0]   wr_dat;

    modport master (
        output lyr_start, lyr_gnt, lyr_line, wr_en, wr_bank, wr_adr, wr_dat,
        input  lyr_vld, lyr_last, lyr_adr, lyr_dat
    );

    modport slave (
        input  lyr_start, lyr_gnt, lyr_line, wr_en, wr_bank, wr_adr, wr_dat,
        output lyr_vld, lyr_last, lyr_adr, lyr_dat
    );
endinterface

// File: rtl/linebuf_fill_sched.sv
// rtl/linebuf_fill_sched.sv - ping-pong line RAM fill scheduler: clear, gfx, txt, spr phases
// Optional abort/fill-time statistics outputs under macro LBSCHED_STATS_EN.
module linebuf_fill_sched #(
    parameter int LINE_W = 768,
    parameter int AW     = 10,
    parameter int DW     = 16
) (
    input  logic                 gclk,
    input  logic                 rstn,
    input  logic                 hcomp,
    input  logic                 vcomp,
    input  logic                 lramsel,
    input  logic [9:0]           next_line,
    input  logic                 line_vis,
    input  logic [DW-1:0]        bg_color,
    input  logic [2:0]           layer_en,
    linebuf_fill_sched_if.master lb,
    output logic                 busy,
    output logic                 overrun
`ifdef LBSCHED_STATS_EN
    ,
    output logic [15:0]          ovr_cnt,
    output logic [11:0]          last_fill_cyc
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GFX, S_TXT, S_SPR, S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            phase_first;
    logic [10:0]     cnt;
    logic            bank_q;
    logic [9:0]      line_q;
    logic            wr_en_q;
    logic [AW-1:0]   wr_adr_q;
    logic [DW-1:0]   wr_dat_q;
    logic            wr_en_d;
    logic [AW-1:0]   wr_adr_d;
    logic [DW-1:0]   wr_dat_d;
    logic            in_fill;
    logic            abort;
    logic [2:0]      lyr_sel;
    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_dat;
    logic            sel_last;
    logic            beat_ok;
    logic            beat_last;

    function automatic state_t first_layer(input logic [2:0] en);
        if (en[0]) return S_GFX;
        if (en[1]) return S_TXT;
        if (en[2]) return S_SPR;
        return S_DONE;
    endfunction

    assign in_fill = (state == S_CLEAR) || (state == S_GFX) ||
                     (state == S_TXT)   || (state == S_SPR);
    assign abort   = hcomp && in_fill;

    // Route the granted requester's beat; a new hcomp kills any beat offered that cycle.
    always_comb begin
        lyr_sel  = 3'b000;
        sel_adr  = '0;
        sel_dat  = '0;
        sel_last = 1'b0;
        case (state)
            S_GFX: begin
                lyr_sel  = 3'b001;
                sel_adr  = lb.lyr_adr[0*AW +: AW];
                sel_dat  = lb.lyr_dat[0*DW +: DW];
                sel_last = lb.lyr_last[0];
            end
            S_TXT: begin
                lyr_sel  = 3'b010;
                sel_adr  = lb.lyr_adr[1*AW +: AW];
                sel_dat  = lb.lyr_dat[1*DW +: DW];
                sel_last = lb.lyr_last[1];
            end
            S_SPR: begin
                lyr_sel  = 3'b100;
                sel_adr  = lb.lyr_adr[2*AW +: AW];
                sel_dat  = lb.lyr_dat[2*DW +: DW];
                sel_last = lb.lyr_last[2];
            end
            default: ;
        endcase
    end

    assign beat_ok   = !hcomp && ((lyr_sel & lb.lyr_vld) != 3'b000);
    assign beat_last = beat_ok && sel_last;

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            phase_first <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_first <= hcomp || (state_nxt != state);
        end
    end

    // An hcomp in any state (re)starts the line; in a fill state that is the abort path.
    always_comb begin
        state_nxt = state;
        if (hcomp) begin
            state_nxt = line_vis ? S_CLEAR : S_DONE;
        end else begin
            case (state)
                S_CLEAR: if (cnt == 11'(LINE_W - 1)) state_nxt = first_layer(layer_en);
                S_GFX:   if (beat_last) state_nxt = first_layer(layer_en & 3'b110);
                S_TXT:   if (beat_last) state_nxt = first_layer(layer_en & 3'b100);
                S_SPR:   if (beat_last) state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy         = in_fill;
        lb.lyr_gnt   = hcomp ? 3'b000 : lyr_sel;
        lb.lyr_start = (hcomp || !phase_first) ? 3'b000 : lyr_sel;
        lb.lyr_line  = line_q;
        lb.wr_bank   = bank_q;
        lb.wr_en     = wr_en_q;
        lb.wr_adr    = wr_adr_q;
        lb.wr_dat    = wr_dat_q;
        wr_en_d      = 1'b0;
        wr_adr_d     = AW'(cnt);
        wr_dat_d     = bg_color;
        if (!hcomp) begin
            if (state == S_CLEAR) begin
                wr_en_d = 1'b1;
            end else if (beat_ok && (sel_dat[DW-1:1] != '0)) begin
                wr_en_d  = 1'b1;
                wr_adr_d = sel_adr;
                wr_dat_d = sel_dat;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            cnt      <= '0;
            bank_q   <= 1'b0;
            line_q   <= '0;
            overrun  <= 1'b0;
            wr_en_q  <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
        end else begin
            if (hcomp) begin
                bank_q <= ~lramsel;
                line_q <= next_line;
                cnt    <= '0;
            end else if (state == S_CLEAR) begin
                cnt <= cnt + 11'd1;
            end
            if (abort) begin
                overrun <= 1'b1;
            end else if (vcomp) begin
                overrun <= 1'b0;
            end
            wr_en_q  <= wr_en_d;
            wr_adr_q <= wr_adr_d;
            wr_dat_q <= wr_dat_d;
        end
    end

`ifdef LBSCHED_STATS_EN
    logic [11:0] fill_cyc;

    // fill_cyc counts cycles elapsed since the starting hcomp; DONE lands one cycle later.
    always_ff @(posedge gclk) begin
        if (!rstn) begin
            ovr_cnt       <= '0;
            fill_cyc      <= '0;
            last_fill_cyc <= '0;
        end else begin
            if (abort && (ovr_cnt != 16'hFFFF)) begin
                ovr_cnt <= ovr_cnt + 16'd1;
            end
            if (hcomp) begin
                fill_cyc <= 12'd1;
            end else if (in_fill && (fill_cyc != 12'hFFF)) begin
                fill_cyc <= fill_cyc + 12'd1;
            end
            if (in_fill && !hcomp && (state_nxt == S_DONE)) begin
                last_fill_cyc <= (fill_cyc == 12'hFFF) ? 12'hFFF : fill_cyc + 12'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_linebuf_fill_sched.sv
// tb/tb_linebuf_fill_sched.sv - randomized self-checking bench for linebuf_fill_sched
module tb_linebuf_fill_sched;
    localparam int AW     = 10;
    localparam int DW     = 16;
    localparam int LINE_W = 768;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic        rstn, hcomp, vcomp, lramsel, line_vis;
    logic [9:0]  next_line;
    logic [15:0] bg_color;
    logic [2:0]  layer_en;
    logic        busy, overrun;
`ifdef LBSCHED_STATS_EN
    logic [15:0] ovr_cnt;
    logic [11:0] last_fill_cyc;
`endif

    linebuf_fill_sched_if #(.AW(AW), .DW(DW)) lb();

    linebuf_fill_sched #(.LINE_W(LINE_W), .AW(AW), .DW(DW)) dut (
        .gclk(gclk), .rstn(rstn), .hcomp(hcomp), .vcomp(vcomp), .lramsel(lramsel),
        .next_line(next_line), .line_vis(line_vis), .bg_color(bg_color),
        .layer_en(layer_en), .lb(lb), .busy(busy), .overrun(overrun)
`ifdef LBSCHED_STATS_EN
        , .ovr_cnt(ovr_cnt), .last_fill_cyc(last_fill_cyc)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [15:0]   ram   [2][1024];
    bit            wrote [2][1024];
    int            wr_cnt, busy_cnt, illegal_wr, bank_err, start_code;
    logic [2:0]    gnt_seen;
    logic          exp_bank, first_bank;
    logic [AW-1:0] first_adr;
    bit            prev_busy, noise_en;
    logic [AW-1:0] qa [3][$];
    logic [15:0]   qd [3][$];
    bit            ql [3][$];

    task automatic reset_log();
        wr_cnt = 0; busy_cnt = 0; illegal_wr = 0; bank_err = 0; start_code = 0;
        gnt_seen = 3'b000;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 1024; a++) begin
                ram[b][a] = 16'h0; wrote[b][a] = 1'b0;
            end
        for (int i = 0; i < 3; i++) begin
            qa[i].delete(); qd[i].delete(); ql[i].delete();
        end
    endtask

    task automatic push_beat(input int l, input int adr, input logic [15:0] dat, input bit last);
        qa[l].push_back(AW'(adr)); qd[l].push_back(dat); ql[l].push_back(last);
    endtask

    // One clock: observe registered outputs, apply strobes, then play the layer requesters.
    task automatic step(input bit hc, input bit vc);
        logic [2:0]      v, l;
        logic [3*AW-1:0] a;
        logic [3*DW-1:0] d;
        @(negedge gclk);
        if (lb.wr_en) begin
            wr_cnt++;
            if (wr_cnt == 1) begin first_adr = lb.wr_adr; first_bank = lb.wr_bank; end
            if (lb.wr_bank !== exp_bank) bank_err++;
            if (!busy && !prev_busy) illegal_wr++;
            ram[lb.wr_bank][lb.wr_adr]   = lb.wr_dat;
            wrote[lb.wr_bank][lb.wr_adr] = 1'b1;
        end
        if (busy) busy_cnt++;
        prev_busy = busy;
        hcomp = hc; vcomp = vc;
        #1;
        if (lb.lyr_start != 3'b000) start_code = start_code * 8 + int'(lb.lyr_start);
        gnt_seen = gnt_seen | lb.lyr_gnt;
        v = '0; l = '0; a = '0; d = '0;
        for (int i = 0; i < 3; i++) begin
            if (lb.lyr_gnt[i]) begin
                if (qa[i].size() > 0 && $urandom_range(3) != 0) begin
                    v[i] = 1'b1;
                    a[i*AW +: AW] = qa[i].pop_front();
                    d[i*DW +: DW] = qd[i].pop_front();
                    l[i] = ql[i].pop_front();
                end
            end else if (noise_en && $urandom_range(1) == 1) begin
                v[i] = 1'b1;
                a[i*AW +: AW] = AW'(800 + $urandom_range(223));
                d[i*DW +: DW] = 16'hFFFE;
                l[i] = 1'($urandom_range(1));
            end
        end
        lb.lyr_vld = v; lb.lyr_last = l; lb.lyr_adr = a; lb.lyr_dat = d;
    endtask

    task automatic run_fill(input int budget, output bit timed_out);
        step(1'b1, 1'b0);
        timed_out = 1'b1;
        for (int n = 0; n < budget; n++) begin
            step(1'b0, 1'b0);
            if (!busy) begin timed_out = 1'b0; break; end
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        checks++;
        if ({busy, overrun, lb.wr_en, lb.wr_bank} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {busy, overrun, lb.wr_en, lb.wr_bank});
        end
        checks++;
        if ({lb.lyr_gnt, lb.lyr_start} !== 6'b0) begin
            errors++; $display("FAIL reset_lyr got %b exp 000000", {lb.lyr_gnt, lb.lyr_start});
        end
        checks++;
        if ({lb.lyr_line, lb.wr_adr, lb.wr_dat} !== 36'h0) begin
            errors++; $display("FAIL reset_bus got %h exp 0", {lb.lyr_line, lb.wr_adr, lb.wr_dat});
        end
`ifdef LBSCHED_STATS_EN
        checks++;
        if ({ovr_cnt, last_fill_cyc} !== 28'h0) begin
            errors++; $display("FAIL reset_stats got %h exp 0", {ovr_cnt, last_fill_cyc});
        end
`endif
        rstn = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic test_clear_only();
        bit to;
        int bad;
        reset_log();
        noise_en = 1'b0; layer_en = 3'b000; lramsel = 1'b0; line_vis = 1'b1;
        bg_color = 16'h0421; exp_bank = 1'b1;
        run_fill(2000, to);
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            if (a < LINE_W && (!wrote[1][a] || ram[1][a] !== 16'h0421)) bad++;
            if (a >= LINE_W && wrote[1][a]) bad++;
            if (wrote[0][a]) bad++;
        end
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL clear_timeout got %0d exp 0", to); end
        checks++;
        if (wr_cnt !== LINE_W) begin errors++; $display("FAIL clear_wr_cnt got %0d exp %0d", wr_cnt, LINE_W); end
        checks++;
        if (bad !== 0 || bank_err !== 0) begin
            errors++; $display("FAIL clear_image got %0d bad %0d bank exp 0 0", bad, bank_err);
        end
        checks++;
        if (busy_cnt !== LINE_W) begin errors++; $display("FAIL clear_busy got %0d exp %0d", busy_cnt, LINE_W); end
        checks++;
        if (start_code !== 0 || illegal_wr !== 0) begin
            errors++; $display("FAIL clear_quiet got %0d start %0d wr exp 0 0", start_code, illegal_wr);
        end
    endtask

    task automatic test_layer_order();
        bit to;
        reset_log();
        noise_en = 1'b0; layer_en = 3'b101; lramsel = 1'b1; line_vis = 1'b1;
        bg_color = 16'h3C3C; exp_bank = 1'b0;
        push_beat(0, 5, 16'h8000, 1'b1);
        push_beat(1, 7, 16'h1234, 1'b1);
        push_beat(2, 5, 16'h0000, 1'b0);
        push_beat(2, 6, 16'h0002, 1'b1);
        run_fill(2000, to);
        checks++;
        if (to !== 1'b0 || ram[0][5] !== 16'h8000) begin
            errors++; $display("FAIL order_adr5 got %h exp 8000 (to=%0d)", ram[0][5], to);
        end
        checks++;
        if (ram[0][6] !== 16'h0002 || ram[0][7] !== 16'h3C3C) begin
            errors++; $display("FAIL order_adr6_7 got %h %h exp 0002 3c3c", ram[0][6], ram[0][7]);
        end
        checks++;
        if (start_code !== 12 || gnt_seen !== 3'b101) begin
            errors++; $display("FAIL order_start got %0d gnt %b exp 12 101", start_code, gnt_seen);
        end
        checks++;
        if (wr_cnt !== LINE_W + 2) begin errors++; $display("FAIL order_wr_cnt got %0d exp %0d", wr_cnt, LINE_W + 2); end
    endtask

    task automatic test_invisible();
        bit to;
        logic [9:0] ln;
        reset_log();
        ln = 10'($urandom_range(1023));
        next_line = ln; line_vis = 1'b0; layer_en = 3'b111; exp_bank = ~lramsel;
        run_fill(50, to);
        repeat (10) step(1'b0, 1'b0);
        checks++;
        if (wr_cnt !== 0 || busy_cnt !== 0 || start_code !== 0) begin
            errors++; $display("FAIL invis_quiet got wr %0d busy %0d start %0d exp 0 0 0", wr_cnt, busy_cnt, start_code);
        end
        checks++;
        if (lb.lyr_line !== ln) begin errors++; $display("FAIL invis_line got %0d exp %0d", lb.lyr_line, ln); end
        line_vis = 1'b1;
    endtask

    task automatic test_random_fills(input int iters);
        logic [15:0] exp_img [1024];
        bit          exp_w   [1024];
        int          exp_wr, exp_code, nb, adr, bad;
        logic [15:0] dat;
        logic [9:0]  ln;
        bit          to;
        for (int it = 0; it < iters; it++) begin
            reset_log();
            noise_en = 1'b1;
            layer_en = 3'($urandom_range(7));
            lramsel  = 1'($urandom_range(1));
            bg_color = 16'($urandom);
            ln = 10'($urandom_range(1023));
            next_line = ln; exp_bank = ~lramsel;
            exp_wr = LINE_W; exp_code = 0;
            for (int a = 0; a < 1024; a++) begin exp_w[a] = (a < LINE_W); exp_img[a] = bg_color; end
            for (int L = 0; L < 3; L++) begin
                if (layer_en[L]) begin
                    exp_code = exp_code * 8 + (1 << L);
                    nb = 1 + $urandom_range(5);
                    for (int k = 0; k < nb; k++) begin
                        adr = $urandom_range(LINE_W - 1);
                        dat = ($urandom_range(2) == 0) ? 16'($urandom_range(1)) : 16'($urandom);
                        push_beat(L, adr, dat, k == nb - 1);
                        if (dat[15:1] != 15'h0) begin exp_img[adr] = dat; exp_wr++; end
                    end
                end
            end
            run_fill(3000, to);
            bad = 0;
            for (int a = 0; a < 1024; a++) begin
                if (wrote[exp_bank][a] != exp_w[a]) bad++;
                else if (exp_w[a] && ram[exp_bank][a] !== exp_img[a]) bad++;
            end
            checks++;
            if (to !== 1'b0 || bad !== 0) begin
                errors++; $display("FAIL rand_image it %0d got %0d bad to=%0d exp 0", it, bad, to);
            end
            checks++;
            if (wr_cnt !== exp_wr || bank_err !== 0 || illegal_wr !== 0) begin
                errors++; $display("FAIL rand_writes it %0d got %0d/%0d/%0d exp %0d/0/0", it, wr_cnt, bank_err, illegal_wr, exp_wr);
            end
            checks++;
            if (start_code !== exp_code || gnt_seen !== layer_en || lb.lyr_line !== ln) begin
                errors++; $display("FAIL rand_phases it %0d got %0d %b %0d exp %0d %b %0d", it, start_code, gnt_seen, lb.lyr_line, exp_code, layer_en, ln);
            end
        end
        noise_en = 1'b0;
    endtask

    task automatic test_overrun();
        reset_log();
        noise_en = 1'b0; layer_en = 3'b001; lramsel = 1'b0; line_vis = 1'b1;
        bg_color = 16'h5A5A; exp_bank = 1'b1;
        for (int k = 0; k < 300; k++) push_beat(0, $urandom_range(LINE_W - 1), 16'hF00E, 1'b0);
        step(1'b1, 1'b0);
        repeat (899) step(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_pre got busy %b ovr %b exp 1 0", busy, overrun);
        end
        lramsel = 1'b1;
        step(1'b1, 1'b0);
        wr_cnt = 0; bank_err = 0; exp_bank = 1'b0;
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL ovr_set got ovr %b busy %b exp 1 1", overrun, busy);
        end
        checks++;
        if (wr_cnt !== 3 || first_adr !== '0 || first_bank !== 1'b0 || bank_err !== 0 || ram[0][0] !== 16'h5A5A) begin
            errors++; $display("FAIL ovr_restart got cnt %0d adr %0d bank %b berr %0d exp 3 0 0 0", wr_cnt, first_adr, first_bank, bank_err);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_vcomp_clear got %b exp 0", overrun); end
`ifdef LBSCHED_STATS_EN
        checks++;
        if (ovr_cnt !== 16'd1) begin errors++; $display("FAIL ovr_cnt got %0d exp 1", ovr_cnt); end
`endif
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
    endtask

    task automatic test_reset_mid_fill();
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            step(1'b0, 1'b0);
            if (lb.lyr_gnt[0]) begin hit = 1'b1; break; end
        end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL midrst_reach_gfx got %b exp 1", hit); end
        rstn = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if ({busy, overrun, lb.wr_en, lb.wr_bank, lb.lyr_gnt, lb.lyr_start} !== 10'b0 || lb.lyr_line !== 10'h0) begin
            errors++; $display("FAIL midrst_outputs got %b line %0d exp 0 0", {busy, overrun, lb.wr_en, lb.wr_bank, lb.lyr_gnt, lb.lyr_start}, lb.lyr_line);
        end
        rstn = 1'b1;
        busy_cnt = 0; wr_cnt = 0;
        repeat (5) step(1'b0, 1'b0);
        checks++;
        if (busy_cnt !== 0 || wr_cnt !== 0) begin
            errors++; $display("FAIL midrst_idle got busy %0d wr %0d exp 0 0", busy_cnt, wr_cnt);
        end
    endtask

    initial begin
        rstn = 1'b0; hcomp = 1'b0; vcomp = 1'b0; lramsel = 1'b0; line_vis = 1'b1;
        next_line = '0; bg_color = '0; layer_en = '0; noise_en = 1'b0; prev_busy = 1'b0;
        exp_bank = 1'b0;
        lb.lyr_vld = '0; lb.lyr_last = '0; lb.lyr_adr = '0; lb.lyr_dat = '0;
        reset_log();
        test_reset();
        test_clear_only();
        test_layer_order();
        test_invisible();
        test_random_fills(8);
        test_overrun();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
